// File: rtl/rv_initiator.sv
// rtl/rv_initiator.sv - single-outstanding ready/valid bus initiator with per-phase timeout
module rv_initiator #(
  parameter int WRITE_WIDTH = 8,
  parameter int READ_WIDTH  = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  // command side
  input  logic                   CMD_VALID_I,
  output logic                   CMD_READY_O,
  input  logic                   CMD_WRITE_I,
  input  logic [WRITE_WIDTH-1:0] CMD_DATA_I,
  // write channel to responder
  output logic                   WRITE_VALID_O,
  input  logic                   WRITE_READY_I,
  output logic [WRITE_WIDTH-1:0] WRITE_DATA_O,
  // read channel from responder
  output logic                   READ_READY_O,
  input  logic                   READ_VALID_I,
  input  logic [READ_WIDTH-1:0]  READ_DATA_I,
  // response side
  output logic                   RSP_VALID_O,
  input  logic                   RSP_READY_I,
  output logic [READ_WIDTH-1:0]  RSP_DATA_O,
  output logic                   RSP_ERR_O,
  output logic                   BUSY_O
);

  // Timer is at least one bit wide so a disabled timeout still elaborates cleanly.
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TLIM_W = TW'(TLIM);
  localparam logic [TW-1:0] TSAT_W = {TW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WRITE_WIDTH-1:0] r_wdata;
  logic [READ_WIDTH-1:0]  r_rsp_data;
  logic                   r_rsp_err;
  logic [TW-1:0]          r_timer;

  logic w_accept;
  logic w_wr_hs;
  logic w_rd_hs;
  logic w_bus;
  logic w_expire;
  logic w_timeout;

  // Handshakes only count in the state that owns the channel; stray strobes elsewhere are ignored.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && CMD_VALID_I;
    w_wr_hs   = (r_state == S_WRITE) && WRITE_READY_I;
    w_rd_hs   = (r_state == S_READ) && READ_VALID_I;
    w_bus     = (r_state == S_WRITE) || (r_state == S_READ);
    w_expire  = (TIMEOUT > 0) && (r_timer == TLIM_W);
    w_timeout = w_bus && w_expire && !w_wr_hs && !w_rd_hs;
  end

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a handshake in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (CMD_VALID_I) begin
          w_state_nxt = CMD_WRITE_I ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (WRITE_READY_I || w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_READ: begin
        if (READ_VALID_I || w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY_I) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Channel strobes are pure decodes of the registered state.
  always_comb begin
    CMD_READY_O   = 1'b0;
    WRITE_VALID_O = 1'b0;
    READ_READY_O  = 1'b0;
    RSP_VALID_O   = 1'b0;
    BUSY_O        = 1'b1;
    case (r_state)
      S_IDLE: begin
        CMD_READY_O = 1'b1;
        BUSY_O      = 1'b0;
      end
      S_WRITE: WRITE_VALID_O = 1'b1;
      S_READ:  READ_READY_O  = 1'b1;
      S_RESP:  RSP_VALID_O   = 1'b1;
      default: BUSY_O        = 1'b1;
    endcase
  end

  // Payload latch and response capture; response registers only change on entry to RESP.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wdata <= CMD_DATA_I;
      end
      if (w_rd_hs) begin
        r_rsp_data <= READ_DATA_I;
        r_rsp_err  <= 1'b0;
      end else if (w_wr_hs) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  // Phase timer: counts bus-phase cycles, saturates, and sits at zero outside the bus phase.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_timer <= '0;
    end else if (w_bus) begin
      if (r_timer != TSAT_W) begin
        r_timer <= r_timer + TW'(1);
      end
    end else begin
      r_timer <= '0;
    end
  end

  assign WRITE_DATA_O = r_wdata;
  assign RSP_DATA_O   = r_rsp_data;
  assign RSP_ERR_O    = r_rsp_err;

endmodule

// File: tb/tb_rv_initiator.sv
// tb/tb_rv_initiator.sv - scoreboard bench for rv_initiator
module tb_rv_initiator;

  localparam int TO = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       RST_I;
  logic       CMD_VALID_I, CMD_READY_O, CMD_WRITE_I;
  logic [7:0] CMD_DATA_I;
  logic       WRITE_VALID_O, WRITE_READY_I;
  logic [7:0] WRITE_DATA_O;
  logic       READ_READY_O, READ_VALID_I;
  logic [7:0] READ_DATA_I;
  logic       RSP_VALID_O, RSP_READY_I;
  logic [7:0] RSP_DATA_O;
  logic       RSP_ERR_O, BUSY_O;

  logic       z_CMD_VALID_I, z_CMD_READY_O, z_CMD_WRITE_I;
  logic [7:0] z_CMD_DATA_I;
  logic       z_WRITE_VALID_O, z_WRITE_READY_I;
  logic [7:0] z_WRITE_DATA_O;
  logic       z_READ_READY_O, z_READ_VALID_I;
  logic [7:0] z_READ_DATA_I;
  logic       z_RSP_VALID_O, z_RSP_READY_I;
  logic [7:0] z_RSP_DATA_O;
  logic       z_RSP_ERR_O, z_BUSY_O;

  rv_initiator #(.WRITE_WIDTH(8), .READ_WIDTH(8), .TIMEOUT(TO)) dut (
    .CLK_I(clk), .RST_I(RST_I),
    .CMD_VALID_I(CMD_VALID_I), .CMD_READY_O(CMD_READY_O), .CMD_WRITE_I(CMD_WRITE_I), .CMD_DATA_I(CMD_DATA_I),
    .WRITE_VALID_O(WRITE_VALID_O), .WRITE_READY_I(WRITE_READY_I), .WRITE_DATA_O(WRITE_DATA_O),
    .READ_READY_O(READ_READY_O), .READ_VALID_I(READ_VALID_I), .READ_DATA_I(READ_DATA_I),
    .RSP_VALID_O(RSP_VALID_O), .RSP_READY_I(RSP_READY_I), .RSP_DATA_O(RSP_DATA_O), .RSP_ERR_O(RSP_ERR_O),
    .BUSY_O(BUSY_O)
  );

  rv_initiator #(.WRITE_WIDTH(8), .READ_WIDTH(8), .TIMEOUT(0)) dut0 (
    .CLK_I(clk), .RST_I(RST_I),
    .CMD_VALID_I(z_CMD_VALID_I), .CMD_READY_O(z_CMD_READY_O), .CMD_WRITE_I(z_CMD_WRITE_I), .CMD_DATA_I(z_CMD_DATA_I),
    .WRITE_VALID_O(z_WRITE_VALID_O), .WRITE_READY_I(z_WRITE_READY_I), .WRITE_DATA_O(z_WRITE_DATA_O),
    .READ_READY_O(z_READ_READY_O), .READ_VALID_I(z_READ_VALID_I), .READ_DATA_I(z_READ_DATA_I),
    .RSP_VALID_O(z_RSP_VALID_O), .RSP_READY_I(z_RSP_READY_I), .RSP_DATA_O(z_RSP_DATA_O), .RSP_ERR_O(z_RSP_ERR_O),
    .BUSY_O(z_BUSY_O)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       exp_q[$];
  rsp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected response whenever the DUT completes a response handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wv_rr_exclusive", {31'd0, WRITE_VALID_O & READ_READY_O}, 0);
      if (RSP_VALID_O) chk("cmd_ready_in_resp", CMD_READY_O, 0);
      if (hold_prev) begin
        chk("rsp_valid_hold", RSP_VALID_O, 1);
        chk("rsp_data_stable", RSP_DATA_O, prev_data);
        chk("rsp_err_stable", RSP_ERR_O, prev_err);
      end
      if (RSP_VALID_O && RSP_READY_I) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data 0x%0h err %0b expected no response", RSP_DATA_O, RSP_ERR_O);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", RSP_DATA_O, mon_e.data);
          chk("rsp_err", RSP_ERR_O, mon_e.err);
        end
      end
      hold_prev = RSP_VALID_O && !RSP_READY_I;
      prev_data = RSP_DATA_O;
      prev_err  = RSP_ERR_O;
    end
  end

  // One full transaction: responder answers after dly bus cycles, consumer stalls rsp_dly cycles.
  task automatic do_txn(input bit wr, input logic [7:0] d, input logic [7:0] rd, input int dly, input int rsp_dly);
    int   n;
    int   nb;
    rsp_t e;
    n = 0;
    while (!CMD_READY_O && n < 50) begin
      tick();
      n++;
    end
    if (!CMD_READY_O) begin
      chk("cmd_ready_wait", CMD_READY_O, 1);
      return;
    end
    CMD_VALID_I = 1'b1;
    CMD_WRITE_I = wr;
    CMD_DATA_I  = d;
    tick();
    CMD_VALID_I = 1'b0;
    CMD_DATA_I  = 8'($urandom);
    // Reference: handshake at bus cycle dly wins unless the phase limit of TO cycles runs out first.
    e.err  = (dly >= TO);
    e.data = (wr || e.err) ? 8'h00 : rd;
    nb     = e.err ? TO : dly + 1;
    exp_q.push_back(e);
    for (int k = 0; k < nb; k++) begin
      chk("write_valid_bus", WRITE_VALID_O, wr);
      chk("read_ready_bus", READ_READY_O, !wr);
      chk("rsp_valid_bus", RSP_VALID_O, 0);
      chk("busy_bus", BUSY_O, 1);
      if (wr) chk("write_data", WRITE_DATA_O, d);
      if (wr) begin
        WRITE_READY_I = (k == dly);
        READ_VALID_I  = 1'($urandom);
        READ_DATA_I   = 8'($urandom);
      end else begin
        READ_VALID_I  = (k == dly);
        READ_DATA_I   = (k == dly) ? rd : 8'($urandom);
        WRITE_READY_I = 1'($urandom);
      end
      tick();
    end
    WRITE_READY_I = 1'b0;
    READ_VALID_I  = 1'b0;
    chk("rsp_valid_entry", RSP_VALID_O, 1);
    chk("write_valid_resp", WRITE_VALID_O, 0);
    chk("read_ready_resp", READ_READY_O, 0);
    for (int r = 0; r < rsp_dly; r++) begin
      RSP_READY_I   = 1'b0;
      WRITE_READY_I = 1'($urandom);
      READ_VALID_I  = 1'($urandom);
      tick();
    end
    RSP_READY_I = 1'b1;
    CMD_VALID_I = 1'b1;
    CMD_WRITE_I = 1'b1;
    tick();
    RSP_READY_I   = 1'b0;
    CMD_VALID_I   = 1'b0;
    WRITE_READY_I = 1'b0;
    READ_VALID_I  = 1'b0;
    chk("idle_after_rsp", CMD_READY_O, 1);
    chk("no_accept_in_resp", WRITE_VALID_O, 0);
    chk("rsp_data_hold_idle", RSP_DATA_O, e.data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    RST_I = 1'b1;
    CMD_VALID_I = 0; CMD_WRITE_I = 0; CMD_DATA_I = 0;
    WRITE_READY_I = 0; READ_VALID_I = 0; READ_DATA_I = 0; RSP_READY_I = 0;
    z_CMD_VALID_I = 0; z_CMD_WRITE_I = 0; z_CMD_DATA_I = 0;
    z_WRITE_READY_I = 0; z_READ_VALID_I = 0; z_READ_DATA_I = 0; z_RSP_READY_I = 0;
    repeat (3) tick();
    RST_I = 1'b0;
    tick();
    chk("rst_cmd_ready", CMD_READY_O, 1);
    chk("rst_write_valid", WRITE_VALID_O, 0);
    chk("rst_read_ready", READ_READY_O, 0);
    chk("rst_rsp_valid", RSP_VALID_O, 0);
    chk("rst_busy", BUSY_O, 0);
    chk("rst_write_data", WRITE_DATA_O, 0);
    chk("rst_rsp_data", RSP_DATA_O, 0);
    chk("rst_rsp_err", RSP_ERR_O, 0);
    mon_en = 1'b1;

    do_txn(1'b1, 8'hA5, 8'h00, 1, 0);
    do_txn(1'b0, 8'h00, 8'h3C, 3, 0);
    do_txn(1'b0, 8'h00, 8'h55, 100, 1);
    do_txn(1'b1, 8'h11, 8'h00, 0, 5);
    do_txn(1'b0, 8'h00, 8'h99, TO - 1, 2);
    do_txn(1'b0, 8'h00, 8'h77, TO, 0);
    do_txn(1'b1, 8'hC3, 8'h00, TO + 3, 0);
    do_txn(1'b0, 8'h00, 8'hE1, 2, 0);

    // Reset during WRITE aborts without a response and clears the response registers.
    CMD_VALID_I = 1'b1; CMD_WRITE_I = 1'b1; CMD_DATA_I = 8'h5A;
    tick();
    CMD_VALID_I = 1'b0;
    chk("pre_rst_write_valid", WRITE_VALID_O, 1);
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    chk("midrst_write_valid", WRITE_VALID_O, 0);
    chk("midrst_cmd_ready", CMD_READY_O, 1);
    chk("midrst_rsp_valid", RSP_VALID_O, 0);
    chk("midrst_write_data", WRITE_DATA_O, 0);
    chk("midrst_rsp_data", RSP_DATA_O, 0);
    seen = 1'b0;
    repeat (4) begin
      WRITE_READY_I = 1'b1;
      tick();
      seen = seen | RSP_VALID_O;
    end
    WRITE_READY_I = 1'b0;
    chk("midrst_no_rsp", seen, 0);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 4)));
    end

    // TIMEOUT=0 instance: a 100-cycle responder stall must complete without error.
    z_CMD_VALID_I = 1'b1; z_CMD_WRITE_I = 1'b1; z_CMD_DATA_I = 8'h66;
    tick();
    z_CMD_VALID_I = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      seen = seen | z_RSP_VALID_O | !z_WRITE_VALID_O;
      tick();
    end
    chk("to0_still_waiting", seen, 0);
    chk("to0_write_data", z_WRITE_DATA_O, 8'h66);
    z_WRITE_READY_I = 1'b1;
    tick();
    z_WRITE_READY_I = 1'b0;
    chk("to0_rsp_valid", z_RSP_VALID_O, 1);
    chk("to0_rsp_err", z_RSP_ERR_O, 0);
    chk("to0_rsp_data", z_RSP_DATA_O, 0);
    z_RSP_READY_I = 1'b1;
    tick();
    z_RSP_READY_I = 1'b0;
    chk("to0_idle", z_CMD_READY_O, 1);

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
